// File: rtl/ring_counter_pkg.sv
// rtl/ring_counter_pkg.sv - shared defaults and rotate-direction encodings for ring_counter_4bit
package ring_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = 4'b0001;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/ring_onehot_check.sv
// rtl/ring_onehot_check.sv - combinational one-hot detector (only used under RING_COUNTER_SELFCORRECT_EN)
module ring_onehot_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             onehot_o
);

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_counter_4bit.sv
// rtl/ring_counter_4bit.sv - one-hot ring counter; RING_COUNTER_SELFCORRECT_EN adds recovery to RESET_VALUE
module ring_counter_4bit
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE),
  parameter int               SHIFT_LEFT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] rot;

  generate
    if (SHIFT_LEFT == int'(DIR_LEFT)) begin : g_left
      assign rot = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
    end else begin : g_right
      assign rot = {out_q[0], out_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef RING_COUNTER_SELFCORRECT_EN
  logic onehot;

  ring_onehot_check #(
    .WIDTH(WIDTH)
  ) u_onehot_check (
    .vec_i   (out_q),
    .onehot_o(onehot)
  );

  // A corrupted ring is reloaded instead of rotated so it cannot persist.
  always_comb begin
    out_d = rot;
    if (!onehot) begin
      out_d = RESET_VALUE;
    end
  end
`else
  always_comb begin
    out_d = rot;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_ring_counter_4bit.sv
// tb/tb_ring_counter_4bit.sv - scoreboard bench for ring_counter_4bit (left, right and non-one-hot instances)
module tb_ring_counter_4bit;

  localparam int NSTEP = 19;

  typedef struct {
    logic [3:0] l;
    logic [3:0] r;
    logic [3:0] z;
    logic [3:0] f;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] out_l;
  logic [3:0] out_r;
  logic [3:0] out_z;
  logic [3:0] out_f;

  exp_t sb_q[$];
  int   n_vec;
  int   n_bad;

  // Stimulus table: reset level, glitch flag, hand-computed expected outputs.
  logic       rst_t [NSTEP] = '{0,0,0,0,0, 1,1,1,1,1,1,1,1, 1,1, 0, 1, 1, 1};
  logic       gl_t  [NSTEP] = '{0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0, 0, 0, 1, 0};
  logic [3:0] el_t  [NSTEP] = '{4'b0001,4'b0001,4'b0001,4'b0001,4'b0001,
                                4'b0010,4'b0100,4'b1000,4'b0001,4'b0010,4'b0100,4'b1000,4'b0001,
                                4'b0010,4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] er_t  [NSTEP] = '{4'b0001,4'b0001,4'b0001,4'b0001,4'b0001,
                                4'b1000,4'b0100,4'b0010,4'b0001,4'b1000,4'b0100,4'b0010,4'b0001,
                                4'b1000,4'b0100, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
  logic [3:0] ef_t  [NSTEP] = '{4'b0101,4'b0101,4'b0101,4'b0101,4'b0101,
                                4'b1010,4'b0101,4'b1010,4'b0101,4'b1010,4'b0101,4'b1010,4'b0101,
                                4'b1010,4'b0101, 4'b0101, 4'b1010, 4'b0101, 4'b1010};

  ring_counter_4bit dut (
    .clk  (clk),
    .reset(reset),
    .out  (out_l)
  );

  ring_counter_4bit #(.SHIFT_LEFT(0)) dut_r (
    .clk  (clk),
    .reset(reset),
    .out  (out_r)
  );

  ring_counter_4bit #(.RESET_VALUE(4'b0000)) dut_z (
    .clk  (clk),
    .reset(reset),
    .out  (out_z)
  );

  ring_counter_4bit #(.RESET_VALUE(4'b0101)) dut_f (
    .clk  (clk),
    .reset(reset),
    .out  (out_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("rotate_left", out_l, e.l);
      check("rotate_right", out_r, e.r);
      check("zero_state", out_z, e.z);
      check("multi_hot", out_f, e.f);
    end
  end

  initial begin
    exp_t e;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    for (int i = 0; i < NSTEP; i++) begin
      @(negedge clk);
      reset = rst_t[i];
      e.l = el_t[i];
      e.r = er_t[i];
      e.z = 4'b0000;
`ifdef RING_COUNTER_SELFCORRECT_EN
      e.f = 4'b0101;
`else
      e.f = ef_t[i];
`endif
      sb_q.push_back(e);
      if (gl_t[i]) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
